// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with valid/ready on both sides
// and programmable almost-full / almost-empty status.
module sync_fifo #(
  parameter int FIFO_DEPTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int WIDTH      = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid_s,
  input  logic                  i_ready_m,
  input  logic [WIDTH-1:0]      i_almostempty_lvl,
  input  logic [WIDTH-1:0]      i_almostfull_lvl,
  input  logic [DATA_WIDTH-1:0] i_datain,
  output logic                  o_almostfull,
  output logic                  o_full,
  output logic                  o_ready_s,
  output logic                  o_valid_m,
  output logic                  o_almostempty,
  output logic                  o_empty,
  output logic [DATA_WIDTH-1:0] o_dataout
);

  localparam int AW = $clog2(FIFO_DEPTH);
  // Common width so thresholds and count are both zero-extended before compare.
  localparam int CW = (WIDTH > AW + 1) ? WIDTH : AW + 1;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW:0]           count;
  logic                  wr_en;
  logic                  rd_en;
  logic [CW-1:0]         count_x;
  logic [CW-1:0]         af_x;
  logic [CW-1:0]         ae_x;

  assign o_full    = (count == (AW + 1)'(FIFO_DEPTH));
  assign o_empty   = (count == '0);
  assign o_ready_s = !o_full;
  assign o_valid_m = !o_empty;

  assign wr_en = i_valid_s & o_ready_s;
  assign rd_en = i_ready_m & o_valid_m;

  assign count_x       = CW'(count);
  assign af_x          = CW'(i_almostfull_lvl);
  assign ae_x          = CW'(i_almostempty_lvl);
  assign o_almostfull  = (count_x >= af_x);
  assign o_almostempty = (count_x <= ae_x);

  assign o_dataout = o_empty ? '0 : mem[rd_ptr];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; stale words are hidden by the empty gating on o_dataout.
  always_ff @(posedge i_clk) begin
    if (wr_en && !i_rst) mem[wr_ptr] <= i_datain;
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Randomized bench for sync_fifo against a queue-based reference model.
module tb_sync_fifo;

  localparam int DEPTH = 8;
  localparam int DW    = 32;
  localparam int LW    = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid_s;
  logic          ready_m;
  logic [LW-1:0] ae_lvl;
  logic [LW-1:0] af_lvl;
  logic [DW-1:0] datain;
  logic          almostfull;
  logic          full;
  logic          ready_s;
  logic          valid_m;
  logic          almostempty;
  logic          empty;
  logic [DW-1:0] dataout;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] model_q [$];

  always #5 clk = ~clk;

  sync_fifo #(.FIFO_DEPTH(DEPTH), .DATA_WIDTH(DW), .WIDTH(LW)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_valid_s(valid_s),
    .i_ready_m(ready_m),
    .i_almostempty_lvl(ae_lvl),
    .i_almostfull_lvl(af_lvl),
    .i_datain(datain),
    .o_almostfull(almostfull),
    .o_full(full),
    .o_ready_s(ready_s),
    .o_valid_m(valid_m),
    .o_almostempty(almostempty),
    .o_empty(empty),
    .o_dataout(dataout)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Compare every output against the model's view of the current occupancy.
  task automatic check_all(input string where);
    int n;
    n = model_q.size();
    chk({where, ":empty"},   64'(empty),       64'(n == 0));
    chk({where, ":full"},    64'(full),        64'(n == DEPTH));
    chk({where, ":ready_s"}, 64'(ready_s),     64'(n != DEPTH));
    chk({where, ":valid_m"}, 64'(valid_m),     64'(n != 0));
    chk({where, ":afull"},   64'(almostfull),  64'(n >= int'(af_lvl)));
    chk({where, ":aempty"},  64'(almostempty), 64'(n <= int'(ae_lvl)));
    chk({where, ":data"},    64'(dataout),     (n == 0) ? 64'd0 : 64'(model_q[0]));
  endtask

  // Apply one clock edge to the model using the currently driven inputs.
  task automatic step;
    bit do_wr;
    bit do_rd;
    do_wr = valid_s && (model_q.size() < DEPTH);
    do_rd = ready_m && (model_q.size() > 0);
    @(posedge clk);
    if (rst) begin
      model_q.delete();
    end else begin
      if (do_rd) void'(model_q.pop_front());
      if (do_wr) model_q.push_back(datain);
    end
    #1;
  endtask

  initial begin
    int pv;
    int pr;
    rst     = 1'b1;
    valid_s = 1'b0;
    ready_m = 1'b0;
    ae_lvl  = 8'd2;
    af_lvl  = 8'd5;
    datain  = '0;
    step();
    step();
    check_all("reset");
    rst = 1'b0;

    for (int i = 0; i < 3000; i++) begin
      // Phases bias toward filling, draining, balanced traffic and full-pressure.
      case ((i / 150) % 4)
        0:       begin pv = 90; pr = 10; end
        1:       begin pv = 10; pr = 90; end
        2:       begin pv = 50; pr = 50; end
        default: begin pv = 95; pr = 80; end
      endcase
      valid_s = ($urandom_range(99) < pv);
      ready_m = ($urandom_range(99) < pr);
      datain  = $urandom;
      rst     = ($urandom_range(199) == 0);
      if ($urandom_range(49) == 0) begin
        af_lvl = ($urandom_range(9) == 0) ? 8'($urandom) : 8'($urandom_range(DEPTH + 1));
        ae_lvl = ($urandom_range(9) == 0) ? 8'($urandom) : 8'($urandom_range(DEPTH + 1));
      end
      #1;
      check_all("cyc");
      step();
    end

    rst     = 1'b0;
    valid_s = 1'b0;
    ready_m = 1'b0;
    #1;
    check_all("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
